// File: rtl/riscv_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package riscv_pkg;

    localparam int WORDSIZE = 32;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_e;

    // The loader takes bytes only while a load is still in progress.
    function automatic logic state_accepts(loader_state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Boot-stream byte handshake plus instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORDSIZE   = riscv_pkg::WORDSIZE
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WORDSIZE-1:0]   imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/word_assembler.sv
// Collects four bytes, least significant first, into one word and flags the
// byte that completes it.
module word_assembler
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                byte_valid,
    input  logic [7:0]          byte_in,
    output logic [WORDSIZE-1:0] word_out,
    output logic                word_complete
);

    logic [1:0]          lane_q, lane_d;
    logic [WORDSIZE-1:0] shift_q, shift_d;

    // Bytes enter at the top and shift down, so the first byte ends in lane 0.
    always_comb begin
        word_out      = {byte_in, shift_q[WORDSIZE-1:8]};
        word_complete = byte_valid && (lane_q == 2'd3);
        lane_d        = lane_q;
        shift_d       = shift_q;
        if (clear) begin
            lane_d  = 2'd0;
            shift_d = '0;
        end else if (byte_valid) begin
            lane_d  = lane_q + 2'd1;
            shift_d = word_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q  <= 2'd0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum byte stream into
// instruction-memory writes and releases the core once the checksum matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORDSIZE   = riscv_pkg::WORDSIZE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart,
    imem_loader_if.slave bus,
    output logic         core_reset,
    output logic         done,
    output logic         error
);
    import riscv_pkg::*;

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    loader_state_e         state_q, state_d;
    logic [CNT_W-1:0]      word_idx_q, word_idx_d;
    logic [CNT_W-1:0]      word_count_q, word_count_d;
    logic [7:0]            csum_q, csum_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [WORDSIZE-1:0]   imem_wdata_q, imem_wdata_d;
    logic                  core_reset_q, core_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  xfer;
    logic                  asm_valid;
    logic                  asm_clear;
    logic [WORDSIZE-1:0]   asm_word;
    logic                  asm_complete;

    assign xfer      = bus.in_valid && in_ready_q;
    assign asm_valid = xfer && (state_q == ST_DATA);
    assign asm_clear = restart && ((state_q == ST_DONE) || (state_q == ST_ERR));

    word_assembler u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (asm_clear),
        .byte_valid    (asm_valid),
        .byte_in       (bus.in_data),
        .word_out      (asm_word),
        .word_complete (asm_complete)
    );

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        word_count_d = word_count_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            ST_LEN: begin
                if (xfer) begin
                    word_count_d = CNT_W'(bus.in_data);
                    if (bus.in_data == 8'd0) begin
                        state_d = ST_CSUM;
                    end else if (int'(bus.in_data) > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ bus.in_data;
                    if (asm_complete) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = asm_word;
                        word_idx_d   = word_idx_q + CNT_W'(1);
                        if (word_idx_d == word_count_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (restart) begin
                    state_d      = ST_LEN;
                    word_idx_d   = '0;
                    word_count_d = '0;
                    csum_d       = '0;
                end
            end
            default: state_d = ST_LEN;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        in_ready_d   = state_accepts(state_d);
        core_reset_d = (state_d != ST_DONE);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LEN;
            word_idx_q   <= '0;
            word_count_q <= '0;
            csum_q       <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            word_count_q <= word_count_d;
            csum_q       <= csum_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_reset     = core_reset_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the instruction-memory word address width (depth 2^ADDR_WIDTH words).
REQ-002 Parameter WORDSIZE, default 32, SHALL set the instruction-memory word width; only 32 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL qualify in_data as a boot-stream byte.
REQ-006 in_data  input  8  SHALL carry the boot-stream byte.
REQ-007 in_ready  output  1  SHALL indicate the loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both high.
REQ-008 restart  input  1  SHALL request a new load from DONE or ERR.
REQ-009 imem_we  output  1  SHALL be the one-cycle instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_WIDTH  SHALL be the word address for imem_we.
REQ-011 imem_wdata  output  WORDSIZE  SHALL be the word written on imem_we.
REQ-012 core_reset  output  1  SHALL hold the processor core in reset while high.
REQ-013 done  output  1  SHALL be high while in DONE.
REQ-014 error  output  1  SHALL be high while in ERR.

Function
REQ-015 Stream format SHALL be: 1 length byte N (word count), then 4*N payload bytes (each word little-endian, word 0 first), then 1 checksum byte equal to the XOR of all payload bytes.
REQ-016 States SHALL be LEN, DATA, CSUM, DONE, ERR; reset enters LEN.
REQ-017 in_ready SHALL be high in LEN, DATA, CSUM and low in DONE, ERR.
REQ-018 LEN: on a transfer, N=0 SHALL go to CSUM; 1 <= N <= 2^ADDR_WIDTH SHALL go to DATA; N > 2^ADDR_WIDTH SHALL go to ERR.
REQ-019 DATA: each transfer SHALL place the byte at lane (byte count mod 4) and XOR it into the running checksum.
REQ-020 On the fourth byte of a word, imem_we SHALL pulse high for exactly the next cycle, with imem_addr = word index (0-based) and imem_wdata = the assembled word.
REQ-021 After word N-1 is accepted, the state SHALL move to CSUM; a non-handshake cycle (in_valid low) SHALL change no state or counter.
REQ-022 CSUM: on a transfer, a byte equal to the running checksum SHALL go to DONE; otherwise SHALL go to ERR.
REQ-023 core_reset SHALL be high in every state except DONE, and SHALL fall in the first cycle of DONE.
REQ-024 restart high in DONE or ERR SHALL return to LEN, clear the counters and checksum, and assert core_reset; restart in LEN, DATA or CSUM SHALL be ignored.
REQ-025 imem_we SHALL never assert outside the cycle after a fourth payload byte; imem_addr and imem_wdata SHALL hold their last values otherwise.
REQ-026 The word index SHALL be ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH finishes without wrap-around.

Reset
REQ-027 Asserting reset SHALL immediately (asynchronously), including mid-load, force: state LEN, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0, counters and checksum=0.
REQ-028 Words already written before a mid-load reset SHALL not be rewritten or cleared by the loader.

Structure
REQ-029 The WORDSIZE constant and the loader state encoding SHALL reside in the shared package riscv_pkg.
REQ-030 Byte-lane assembly SHALL be a single sub-module, word_assembler (shift-in byte, lane counter, word-complete pulse); all other logic stays in imem_loader.

Verification
REQ-031 Stream 02, 13 00 00 00, 93 00 10 00, checksum 0x90 -> writes addr0=0x00000013 and addr1=0x00100093, then DONE, core_reset falls.
REQ-032 Same stream with checksum 0x91 -> both writes occur, ERR, error=1, core_reset stays 1, in_ready=0.
REQ-033 Length byte 0x21 with ADDR_WIDTH=5 -> ERR right after the header, with no imem_we.
REQ-034 N=0x20 with 128 payload bytes and random in_valid gaps -> 32 writes at addresses 0..31 with no wrap-around, then DONE when the checksum matches.
REQ-035 reset pulsed after 6 payload bytes -> outputs return to reset values immediately; a fresh stream 01, EF BE AD DE, 0x22 then writes addr0=0xDEADBEEF and reaches DONE.
REQ-036 restart pulsed in DONE -> LEN, core_reset=1, in_ready=1; restart pulsed during DATA -> no effect.
